// File: rtl/lz4_match_copier_if.sv
`default_nettype none
// ============================================================================
//  Module      : lz4_match_copier_if
//  Description : Literal/match command, history-buffer and output-stream
//                signals of the LZ4 match copier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lz4_match_copier_if #(
    parameter int word_size    = 8,
    parameter int address_size = 4
);
    logic                    lit_valid;
    logic [word_size-1:0]    lit_data;
    logic                    lit_ready;

    logic                    match_valid;
    logic [address_size-1:0] match_offset;
    logic [15:0]             match_len;
    logic                    match_ready;

    logic [address_size-1:0] buf_address_r;
    logic [word_size-1:0]    buf_data_out;
    logic [address_size-1:0] buf_address_w;
    logic [word_size-1:0]    buf_data_in;
    logic                    buf_write;

    logic                    out_valid;
    logic [word_size-1:0]    out_data;
    logic                    copy_done;
    logic                    err;

    // Environment side: sequence parser, output_buffer and downstream consumer.
    modport master (
        output lit_valid, lit_data, match_valid, match_offset, match_len,
        output buf_data_out,
        input  lit_ready, match_ready, buf_address_r, buf_address_w,
        input  buf_data_in, buf_write, out_valid, out_data, copy_done, err
    );

    // Copier side.
    modport slave (
        input  lit_valid, lit_data, match_valid, match_offset, match_len,
        input  buf_data_out,
        output lit_ready, match_ready, buf_address_r, buf_address_w,
        output buf_data_in, buf_write, out_valid, out_data, copy_done, err
    );
endinterface
`default_nettype wire

// File: rtl/lz4_match_copier.sv
`default_nettype none
// ============================================================================
//  Module      : lz4_match_copier
//  Description : Writes literals and copies LZ4 matches (one byte/cycle,
//                overlap-safe) into the history buffer, mirroring every
//                written byte on the output stream.
//                Optional macro LZ4_COPY_BYPASS_EN forwards the previous
//                write for read-first buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
module lz4_match_copier #(
    parameter int word_size    = 8,
    parameter int address_size = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    lz4_match_copier_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    state_t                  state;
    logic [address_size-1:0] wp;
    logic [address_size-1:0] rp;
    logic [15:0]             rd_left;
    logic [15:0]             wr_left;
    logic                    pend;
    logic                    copy_done;
    logic                    err;

    logic                    lit_fire;
    logic                    match_fire;
    logic                    write_en;
    logic [word_size-1:0]    write_data;
    logic [word_size-1:0]    copy_data;

    // A literal always wins over a match offered in the same cycle.
    assign lit_fire   = (state == IDLE) && bus.lit_valid;
    assign match_fire = (state == IDLE) && bus.match_valid && !bus.lit_valid;
    assign write_en   = lit_fire || ((state == COPY) && pend);
    assign write_data = (state == COPY) ? copy_data : bus.lit_data;

`ifdef LZ4_COPY_BYPASS_EN
    logic [address_size-1:0] last_wa;
    logic [address_size-1:0] last_ra;
    logic [word_size-1:0]    last_wd;
    logic                    last_we;

    // With a read-first buffer, a read of the address written on the same
    // edge returns stale data; substitute the byte that was just written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wa <= '0;
            last_ra <= '0;
            last_wd <= '0;
            last_we <= 1'b0;
        end else begin
            last_wa <= wp;
            last_ra <= rp;
            last_wd <= write_data;
            last_we <= write_en;
        end
    end

    assign copy_data = (last_we && (last_wa == last_ra)) ? last_wd : bus.buf_data_out;
`else
    assign copy_data = bus.buf_data_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            rd_left   <= '0;
            wr_left   <= '0;
            pend      <= 1'b0;
            copy_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            copy_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (lit_fire) begin
                        wp <= wp + 1'b1;
                    end else if (match_fire) begin
                        if (bus.match_offset == '0) begin
                            err <= 1'b1;
                        end else if (bus.match_len != 16'd0) begin
                            rp      <= wp - bus.match_offset;
                            rd_left <= bus.match_len;
                            wr_left <= bus.match_len;
                            pend    <= 1'b0;
                            state   <= COPY;
                        end
                    end
                end
                COPY: begin
                    // Read side runs one cycle ahead of the write side.
                    if (rd_left != 16'd0) begin
                        rp      <= rp + 1'b1;
                        rd_left <= rd_left - 16'd1;
                        pend    <= 1'b1;
                    end else begin
                        pend    <= 1'b0;
                    end
                    if (pend) begin
                        wp      <= wp + 1'b1;
                        wr_left <= wr_left - 16'd1;
                        if (wr_left == 16'd1) begin
                            state     <= IDLE;
                            copy_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lit_ready     = (state == IDLE);
    assign bus.match_ready   = (state == IDLE) && !bus.lit_valid;
    assign bus.buf_address_r = rp;
    assign bus.buf_address_w = wp;
    assign bus.buf_data_in   = write_data;
    assign bus.buf_write     = write_en;
    assign bus.out_valid     = write_en;
    assign bus.out_data      = write_data;
    assign bus.copy_done     = copy_done;
    assign bus.err           = err;

endmodule
`default_nettype wire

// File: tb/tb_lz4_match_copier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lz4_match_copier
//  Description : Randomised scoreboard bench for lz4_match_copier with an
//                LZ77 window reference model and an output_buffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lz4_match_copier;

    localparam int WS  = 8;
    localparam int AS  = 4;
    localparam int WIN = 1 << AS;

    logic clk = 1'b0;
    logic rst;

    lz4_match_copier_if #(.word_size(WS), .address_size(AS)) bus ();

    lz4_match_copier #(.word_size(WS), .address_size(AS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // output_buffer model: write-then-read normally, read-first with bypass.
    logic [WS-1:0] mem [WIN];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) mem[i] <= '0;
            bus.buf_data_out <= '0;
        end else begin
`ifdef LZ4_COPY_BYPASS_EN
            bus.buf_data_out <= mem[bus.buf_address_r];
`else
            if (bus.buf_write && (bus.buf_address_w == bus.buf_address_r))
                bus.buf_data_out <= bus.buf_data_in;
            else
                bus.buf_data_out <= mem[bus.buf_address_r];
`endif
            if (bus.buf_write) mem[bus.buf_address_w] <= bus.buf_data_in;
        end
    end

    typedef struct {
        logic [AS-1:0] addr;
        logic [WS-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [WS-1:0] ref_mem [WIN];
    int            ref_wp;
    logic          exp_err;
    int            checks = 0;
    int            fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain LZ77 semantics over a circular window.
    task automatic model_clear();
        for (int i = 0; i < WIN; i++) ref_mem[i] = '0;
        ref_wp  = 0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_put(input logic [WS-1:0] d);
        exp_q.push_back('{addr: AS'(ref_wp), data: d});
        ref_mem[ref_wp] = d;
        ref_wp = (ref_wp + 1) % WIN;
    endtask

    task automatic model_match(input int off, input int len);
        if (off == 0) exp_err = 1'b1;
        else for (int i = 0; i < len; i++) model_put(ref_mem[(ref_wp - off + WIN) % WIN]);
    endtask

    // Monitor: every emitted byte is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         bus.buf_address_w, bus.buf_data_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.buf_address_w), 32'(e.addr));
                check("wr_data", 32'(bus.buf_data_in), 32'(e.data));
                check("out_data", 32'(bus.out_data), 32'(e.data));
            end
        end
    end

    task automatic do_reset();
        rst              = 1'b1;
        bus.lit_valid    = 1'b0;
        bus.lit_data     = '0;
        bus.match_valid  = 1'b0;
        bus.match_offset = '0;
        bus.match_len    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_lit(input logic [WS-1:0] d);
        bus.lit_valid = 1'b1;
        bus.lit_data  = d;
        model_put(d);
        @(negedge clk);
        check("lit_ready", 32'(bus.lit_ready), 32'd1);
        @(posedge clk);
        #1 bus.lit_valid = 1'b0;
    endtask

    // Cycle n after acceptance: writes in cycles 2..len+1, copy_done in len+2.
    task automatic observe_copy(input int off, input int len);
        bit active;
        int nmax;
        active = (off != 0) && (len != 0);
        nmax   = active ? len + 2 : 2;
        for (int n = 1; n <= nmax; n++) begin
            @(negedge clk);
            check("copy_write_slot", 32'(bus.out_valid), 32'(active && n >= 2 && n <= len + 1));
            check("copy_done_slot", 32'(bus.copy_done), 32'(active && n == len + 2));
            if (n == 1) check("lit_ready_in_copy", 32'(bus.lit_ready), 32'(!active));
        end
        @(posedge clk);
        #1 check("err_flag", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic send_match(input int off, input int len);
        bit accepted;
        bus.match_valid  = 1'b1;
        bus.match_offset = AS'(off);
        bus.match_len    = 16'(len);
        model_match(off, len);
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (bus.match_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.match_valid = 1'b0;
        check("match_accept", 32'(accepted), 32'd1);
        if (accepted) observe_copy(off, len);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_lit_ready", 32'(bus.lit_ready), 32'd1);
        check("rst_match_ready", 32'(bus.match_ready), 32'd1);
        check("rst_buf_write", 32'(bus.buf_write), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_copy_done", 32'(bus.copy_done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;

        // Repeating pattern, then next literal must land at wp=9.
        send_lit(8'h41); send_lit(8'h42); send_lit(8'h43);
        send_match(3, 6);
        send_lit(8'h10);

        // Run-length case (offset 1).
        do_reset();
        send_lit(8'h55);
        send_match(1, 5);
        send_lit(8'h11);

        // Pointer wrap: literals at 14,15, copy to 0..3, then wp=4.
        do_reset();
        for (int i = 0; i < 14; i++) send_lit(WS'($urandom));
        send_lit(8'hA0); send_lit(8'hA1);
        send_match(2, 4);
        send_lit(8'h5A);

        // Illegal offset and zero-length match; wp must not move.
        send_match(0, 3);
        send_match(2, 0);
        send_lit(8'h5B);

        // Simultaneous literal and match: literal first.
        bus.lit_valid    = 1'b1;
        bus.lit_data     = 8'h77;
        bus.match_valid  = 1'b1;
        bus.match_offset = AS'(1);
        bus.match_len    = 16'd2;
        model_put(8'h77);
        model_match(1, 2);
        @(negedge clk);
        check("simul_match_ready", 32'(bus.match_ready), 32'd0);
        check("simul_lit_ready", 32'(bus.lit_ready), 32'd1);
        @(posedge clk);
        #1 bus.lit_valid = 1'b0;
        @(negedge clk);
        check("simul_match_next", 32'(bus.match_ready), 32'd1);
        @(posedge clk);
        #1 bus.match_valid = 1'b0;
        observe_copy(1, 2);

        // Reset during the 3rd byte of a len-8 copy.
        do_reset();
        send_lit(8'h01); send_lit(8'h02); send_lit(8'h03);
        bus.match_valid  = 1'b1;
        bus.match_offset = AS'(3);
        bus.match_len    = 16'd8;
        model_match(3, 8);
        @(negedge clk);
        check("rst_test_accept", 32'(bus.match_ready), 32'd1);
        @(posedge clk);
        #1 bus.match_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("third_byte_active", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_buf_write", 32'(bus.buf_write), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_lit_ready", 32'(bus.lit_ready), 32'd1);
        check("midrst_copy_done", 32'(bus.copy_done), 32'd0);
        check("midrst_wp", 32'(bus.buf_address_w), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_no_write", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_lit(8'h99);

        // Randomised mix against the window model.
        for (int k = 0; k < 60; k++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 5)      send_lit(WS'($urandom));
            else if (op < 9) send_match(int'($urandom_range(1, WIN - 1)), int'($urandom_range(0, 20)));
            else             send_match(0, int'($urandom_range(0, 4)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
